// File: rtl/rr_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter.
package rr_arbiter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   localparam int DEF_N        = 8;
   localparam int DEF_MAX_HOLD = 16;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Combinational fixed-priority select: lowest set index wins, one-hot result.
module prio_arbiter #(
   parameter int W = 8
) (
   input  logic [W-1:0] c,
   output logic [W-1:0] onehot
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = c & (~c + W'(1));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until the holder releases.
// Optional tenure limit enabled by defining RR_ARBITER_HOLD_LIMIT_EN.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [idx_w(N)-1:0]  gnt_id
);

   localparam int IW = idx_w(N);

   state_t          state, state_nx;
   logic [IW-1:0]   ptr, ptr_nx;
   logic [N-1:0]    gnt_nx;
   logic [IW-1:0]   id_nx;

   logic [N-1:0]    cand, mask, pick_m, pick_u, win;
   logic [IW-1:0]   win_id;
   logic            holder_req, revoke, load;

   // In IDLE gnt is zero, so this is plain req; in GRANTED the holder is excluded.
   assign cand       = req & ~gnt;
   assign holder_req = |(req & gnt);

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
   end

   prio_arbiter #(.W(N)) u_pick_masked (
      .c      (cand & mask),
      .onehot (pick_m)
   );

   prio_arbiter #(.W(N)) u_pick_all (
      .c      (cand),
      .onehot (pick_u)
   );

   assign win = (|pick_m) ? pick_m : pick_u;

   always_comb begin
      win_id = '0;
      for (int i = 0; i < N; i++) begin
         if (win[i]) begin
            win_id = IW'(i);
         end
      end
   end

`ifdef RR_ARBITER_HOLD_LIMIT_EN
   localparam int               CW  = idx_w(MAX_HOLD);
   localparam logic [CW-1:0]    LIM = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt, cnt_nx;

   assign revoke = (state == GRANTED) && (cnt == LIM) && (|cand);

   // Counter restarts on every new grant and saturates at the limit.
   always_comb begin
      cnt_nx = cnt;
      if (load || state_nx == IDLE) begin
         cnt_nx = '0;
      end else if (state == GRANTED && cnt != LIM) begin
         cnt_nx = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nx;
      end
   end
`else
   assign revoke = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      id_nx    = gnt_id;
      ptr_nx   = ptr;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               load = 1'b1;
            end
         end
         GRANTED: begin
            if (!holder_req || revoke) begin
               if (|cand) begin
                  load = 1'b1;
               end else begin
                  state_nx = IDLE;
                  gnt_nx   = '0;
                  id_nx    = '0;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = '0;
            id_nx    = '0;
         end
      endcase
      if (load) begin
         state_nx = GRANTED;
         gnt_nx   = win;
         id_nx    = win_id;
         ptr_nx   = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         gnt       <= gnt_nx;
         gnt_valid <= |gnt_nx;
         gnt_id    <= id_nx;
      end
   end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised round-robin arbiter with registered one-hot grant and grant-until-release locking, for N requesters sharing one resource. It generalises the 8-bit combinational fixed-priority arbiter (lowest index wins) to fair rotation, a locked tenure and an optional maximum tenure. It sits between requesting masters and a shared bus or port, and the grant drives the downstream mux select directly.

## Interface
- N, default 8: number of requesters, N ≥ 2.
- MAX_HOLD, default 16: maximum consecutive granted cycles per tenure, ≥ 1. Used only when RR_ARBITER_HOLD_LIMIT_EN is defined.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i = requester i. A requester holds its bit high for its whole tenure.
- gnt  output  N  registered grant, one-hot or all-zero.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  $clog2(N)  registered binary index of the granted bit; 0 when gnt_valid = 0.

## Operation
- State: IDLE (no grant) or GRANTED (one holder). Pointer ptr, range 0..N-1, marks the highest-priority index.
- Arbitration function, pure combinational on a candidate vector c:
  - Pick the lowest set index ≥ ptr.
  - If none exists, pick the lowest set index overall (wrap).
- IDLE:
  - req = 0: stay in IDLE, outputs stay 0.
  - Otherwise: arbitrate on req, register the winner, go to GRANTED, set ptr = (winner+1) mod N.
- GRANTED, holder h, while req[h] = 1: hold gnt unchanged. ptr and other requests are ignored.
- GRANTED, req[h] = 0 sampled at an edge: release at that same edge.
  - Arbitrate on req. If non-zero, grant the new winner back-to-back with no idle cycle and update ptr.
  - If req = 0, go to IDLE with gnt = 0.
- Requests raised or dropped by non-holders never disturb the current grant.
- Pointer wrap: winner N-1 sets ptr = 0.

## Timing
- Reset values: gnt = 0, gnt_valid = 0, gnt_id = 0, ptr = 0, state IDLE, hold counter 0.
- Reset is asynchronous: outputs clear immediately when rst_n falls, including mid-tenure. The first arbitration after rst_n rises uses ptr = 0.
- Latency: a req sampled at edge k gives gnt valid after edge k, i.e. one cycle.
- Release latency: a dropped req[h] sampled at edge k clears gnt[h] after edge k. Any next grant appears at the same edge.
- Holder drop and other-requester rise in the same cycle: the rising requester competes in that edge's arbitration.
- gnt, gnt_valid and gnt_id always change together and are glitch-free, because all three are flops.

## Configuration
- RR_ARBITER_HOLD_LIMIT_EN defined:
  - A tenure counter increments each GRANTED cycle and is cleared at every new grant.
  - When the count reaches MAX_HOLD - 1 and req & ~(1<<h) ≠ 0, the grant is revoked at the next edge. Arbitration then runs on req with bit h masked, and ptr updates as usual.
  - If no other requester is pending, the holder keeps the grant and the counter saturates.
- Macro not defined: no counter is present. A holder keeps the grant for as long as req[h] stays high.

## Structure
- Package rr_arbiter_pkg holds:
  - typedef for the state enum (IDLE, GRANTED);
  - function computing the index width from N;
  - localparam defaults for N and MAX_HOLD.
- One sub-module, prio_arbiter: parametrised width, combinational, lowest-index-wins one-hot select.
  - The top instantiates it twice: on the masked vector (c & ~((1<<ptr)-1)) and on the unmasked c.
  - The top uses the masked result if it is non-zero, otherwise the unmasked result.

## Test plan
- Reset with N=8, req = 8'b0000_0110, one clk → gnt = 8'b0000_0010, gnt_id = 1, gnt_valid = 1. With req = 0 → all outputs 0 for 10 cycles.
- Lock and hand-off: hold req = 8'b0000_0110 for 5 cycles, then drop req[1] → gnt stays 0000_0010 for 5 cycles, then becomes 0000_0100 at the release edge with no zero cycle.
- Wrap: after a grant to index 5 (ptr = 6), release it and apply req = 8'b0000_0011 → gnt = 0000_0001, ptr = 1.
- Fairness: req = 8'hFF, each holder drops its bit for one cycle after being granted → grant order is 0, 1, 2, …, 7, 0.
- Hold limit (macro defined, MAX_HOLD = 4): req = 8'b0000_0011 held constantly → gnt alternates 0000_0001 ×4 and 0000_0010 ×4. Without the macro → gnt stays 0000_0001.
- rst_n pulsed low mid-tenure between edges → gnt = 0 immediately. After release, req = 8'b1000_0001 → gnt = 0000_0001.
